change_event_logger: RTL and testbench

//  Downstream consumer of the 4-bit activity count y from the simulation-semantics block.
//  - Samples y on every clock and detects value changes.
//  - Pushes {value, delta} change records into a show-ahead FIFO.
//  - Drains the FIFO to a valid/ready stream, so event activity can be inspected cycle-accurately.

---
 rtl/change_event_logger.sv | 100 ++++++++++
 tb/tb_change_event_logger.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/change_event_logger.sv
// rtl/change_event_logger.sv - samples y_in, logs {value, delta} change records into a show-ahead FIFO.
// Optional push-time stamps on out_ts when CHG_LOG_TIMESTAMP_EN is defined.
module change_event_logger #(
  parameter int DW    = 4,
  parameter int DEPTH = 8,
  parameter int TSW   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DW-1:0]          y_in,
  input  logic                   en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_value,
  output logic [DW-1:0]          out_delta,
`ifdef CHG_LOG_TIMESTAMP_EN
  output logic [TSW-1:0]         out_ts,
`endif
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] y_q;
  logic [DW-1:0] y_prev;
  logic          chg;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] val_mem [DEPTH];
  logic [DW-1:0] dlt_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      y_prev <= '0;
    end else begin
      y_q <= y_in;
      if (en) y_prev <= y_q;
    end
  end

  assign chg   = en & (y_q != y_prev);
  assign full  = (fifo_level == LVL_FULL);
  assign pop   = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_en = chg & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      overflow_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (!wr_en && pop) fifo_level <= fifo_level - 1'b1;
      if (chg && full && !pop && overflow_cnt != 8'hFF)
        overflow_cnt <= overflow_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      val_mem[wr_ptr] <= y_q;
      dlt_mem[wr_ptr] <= y_q - y_prev;
    end
  end

  assign out_valid = (fifo_level != '0);
  assign out_value = out_valid ? val_mem[rd_ptr] : '0;
  assign out_delta = out_valid ? dlt_mem[rd_ptr] : '0;

`ifdef CHG_LOG_TIMESTAMP_EN
  logic [TSW-1:0] ts_cnt;
  logic [TSW-1:0] ts_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) ts_mem[wr_ptr] <= ts_cnt;
  end

  assign out_ts = out_valid ? ts_mem[rd_ptr] : '0;
`else
  // TSW only matters with timestamps; keep a reference so the parameter is legal either way.
  if (TSW < 1) begin : g_tsw_invalid
  end
`endif

endmodule

// File: tb/tb_change_event_logger.sv
// tb/tb_change_event_logger.sv - directed self-checking bench for change_event_logger.
module tb_change_event_logger;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] y_in = 4'd0;
  logic       en = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] out_value;
  logic [3:0] out_delta;
  logic [3:0] fifo_level;
  logic [7:0] overflow_cnt;
`ifdef CHG_LOG_TIMESTAMP_EN
  logic [7:0] out_ts;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  change_event_logger dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .y_in         (y_in),
    .en           (en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_value    (out_value),
    .out_delta    (out_delta),
`ifdef CHG_LOG_TIMESTAMP_EN
    .out_ts       (out_ts),
`endif
    .fifo_level   (fifo_level),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; y_in = 4'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_cmp++; if (overflow_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_ovf: got %0d want 0", overflow_cnt); end
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid[%0d]: got %0b want 0", i, out_valid); end
      n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL idle_level[%0d]: got %0d want 0", i, fifo_level); end
      n_cmp++; if (overflow_cnt !== 8'd0) begin n_bad++; $display("FAIL idle_ovf[%0d]: got %0d want 0", i, overflow_cnt); end
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    y_in = 4'd3;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early: got %0b want 0", out_valid); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %0b want 1", out_valid); end
    n_cmp++; if (out_value !== 4'd3) begin n_bad++; $display("FAIL single_value: got %0d want 3", out_value); end
    n_cmp++; if (out_delta !== 4'd3) begin n_bad++; $display("FAIL single_delta: got %0d want 3", out_delta); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_once: got %0b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] ev [2];
    logic [3:0] ed [2];
    ev[0] = 4'd1; ed[0] = 4'd2;
    ev[1] = 4'd7; ed[1] = 4'd6;
    out_ready = 1'b1; y_in = 4'd15;
    repeat (4) @(negedge clk);
    out_ready = 1'b0; y_in = 4'd1;
    repeat (3) @(negedge clk);
    en = 1'b0; y_in = 4'd7;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (fifo_level !== 4'd2) begin n_bad++; $display("FAIL wrap_level: got %0d want 2", fifo_level); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_valid[%0d]: got %0b want 1", i, out_valid); end
      n_cmp++; if (out_value !== ev[i]) begin n_bad++; $display("FAIL wrap_value[%0d]: got %0d want %0d", i, out_value, ev[i]); end
      n_cmp++; if (out_delta !== ed[i]) begin n_bad++; $display("FAIL wrap_delta[%0d]: got %0d want %0d", i, out_delta, ed[i]); end
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_empty: got %0b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [3:0] vals [10];
    logic [3:0] dl [10];
    logic [3:0] prev;
    vals = '{4'd2, 4'd5, 4'd9, 4'd14, 4'd0, 4'd3, 4'd11, 4'd4, 4'd6, 4'd13};
    prev = 4'd7;
    for (int i = 0; i < 10; i++) begin
      dl[i] = vals[i] - prev;
      prev  = vals[i];
    end
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      y_in = vals[i];
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (fifo_level !== 4'd8) begin n_bad++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
    n_cmp++; if (overflow_cnt !== 8'd2) begin n_bad++; $display("FAIL ovf_cnt: got %0d want 2", overflow_cnt); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (out_value !== vals[i]) begin n_bad++; $display("FAIL ovf_value[%0d]: got %0d want %0d", i, out_value, vals[i]); end
      n_cmp++; if (out_delta !== dl[i]) begin n_bad++; $display("FAIL ovf_delta[%0d]: got %0d want %0d", i, out_delta, dl[i]); end
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty: got %0b want 0", out_valid); end
    n_cmp++; if (overflow_cnt !== 8'd2) begin n_bad++; $display("FAIL ovf_hold: got %0d want 2", overflow_cnt); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 8; i++) begin
      y_in = 4'(i);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (fifo_level !== 4'd8) begin n_bad++; $display("FAIL fpp_fill: got %0d want 8", fifo_level); end
    y_in = 4'd10;
    @(negedge clk);
    n_cmp++; if (fifo_level !== 4'd8) begin n_bad++; $display("FAIL fpp_pre: got %0d want 8", fifo_level); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    n_cmp++; if (fifo_level !== 4'd8) begin n_bad++; $display("FAIL fpp_level: got %0d want 8", fifo_level); end
    n_cmp++; if (overflow_cnt !== 8'd2) begin n_bad++; $display("FAIL fpp_ovf: got %0d want 2", overflow_cnt); end
    for (int i = 0; i < 8; i++) begin
      logic [3:0] ev;
      logic [3:0] ed;
      ev = (i == 7) ? 4'd10 : 4'(i + 2);
      ed = (i == 7) ? 4'd2 : 4'd1;
      n_cmp++; if (out_value !== ev) begin n_bad++; $display("FAIL fpp_value[%0d]: got %0d want %0d", i, out_value, ev); end
      n_cmp++; if (out_delta !== ed) begin n_bad++; $display("FAIL fpp_delta[%0d]: got %0d want %0d", i, out_delta, ed); end
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fpp_empty: got %0b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    for (int i = 3; i <= 7; i++) begin
      y_in = 4'(i);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (fifo_level !== 4'd5) begin n_bad++; $display("FAIL arst_pre: got %0d want 5", fifo_level); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %0b want 0", out_valid); end
    n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL arst_level: got %0d want 0", fifo_level); end
    n_cmp++; if (overflow_cnt !== 8'd0) begin n_bad++; $display("FAIL arst_ovf: got %0d want 0", overflow_cnt); end
    y_in = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef CHG_LOG_TIMESTAMP_EN
  task automatic test_timestamp();
    repeat (6) @(negedge clk);
    y_in = 4'd5;
    repeat (5) @(negedge clk);
    y_in = 4'd9;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_ts !== 8'd7) begin n_bad++; $display("FAIL ts_first: got %0d want 7", out_ts); end
    n_cmp++; if (out_value !== 4'd5) begin n_bad++; $display("FAIL ts_first_value: got %0d want 5", out_value); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    n_cmp++; if (out_ts !== 8'd12) begin n_bad++; $display("FAIL ts_second: got %0d want 12", out_ts); end
    n_cmp++; if (out_value !== 4'd9) begin n_bad++; $display("FAIL ts_second_value: got %0d want 9", out_value); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
`ifdef CHG_LOG_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
